// File: rtl/newton_sched_pkg.sv
// rtl/newton_sched_pkg.sv - shared constants, state codes and default schedule for the Newton enable scheduler
package newton_sched_pkg;

    localparam int NUM_EN          = 20;
    localparam int CNT_W           = 11;
    localparam int ADDR_W          = 5;
    localparam int DEFAULT_RUN_LEN = 70;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Iteration 1: indices 0..5, iteration 2: 6..12, iteration 3: 13..19
    localparam int EN_ADD1_FIFO = 0;
    localparam int EN_MUL1      = 1;
    localparam int EN_ADD1      = 2;
    localparam int EN_MUL2_FIFO = 3;
    localparam int EN_MUL2      = 4;
    localparam int EN_ADD2      = 5;
    localparam int EN_DIV1_FIFO = 6;
    localparam int EN_DIV1      = 7;
    localparam int EN_MUL3_FIFO = 8;
    localparam int EN_MUL3      = 9;
    localparam int EN_ADD3_FIFO = 10;
    localparam int EN_ADD3      = 11;
    localparam int EN_ADD4      = 12;
    localparam int EN_DIV2_FIFO = 13;
    localparam int EN_DIV2      = 14;
    localparam int EN_MUL4_FIFO = 15;
    localparam int EN_MUL4      = 16;
    localparam int EN_ADD5_FIFO = 17;
    localparam int EN_ADD5      = 18;
    localparam int EN_ADD6      = 19;

    // Indices outside the table return all-ones, which keeps that enable off.
    function automatic int unsigned default_thr(input int idx);
        case (idx)
            0:  return 5;
            1:  return 6;
            2:  return 8;
            3:  return 8;
            4:  return 16;
            5:  return 17;
            6:  return 20;
            7:  return 31;
            8:  return 30;
            9:  return 35;
            10: return 36;
            11: return 39;
            12: return 40;
            13: return 44;
            14: return 55;
            15: return 54;
            16: return 57;
            17: return 57;
            18: return 63;
            19: return 64;
            default: return 32'hFFFF_FFFF;
        endcase
    endfunction

endpackage

// File: rtl/newton_sched_cfg_regs.sv
// rtl/newton_sched_cfg_regs.sv - writable threshold table and run length with write-accept and error pulse
module newton_sched_cfg_regs
    import newton_sched_pkg::*;
#(
    parameter int NUM_EN_P = NUM_EN,
    parameter int CNT_W_P  = CNT_W,
    parameter int ADDR_W_P = ADDR_W
) (
    input  logic                         clk,
    input  logic                         asyn_reset,
    input  logic                         idle,
    input  logic                         cfg_we,
    input  logic [ADDR_W_P-1:0]          cfg_addr,
    input  logic [CNT_W_P-1:0]           cfg_wdata,
    output logic                         cfg_err,
    output logic [NUM_EN_P*CNT_W_P-1:0]  thr_flat,
    output logic [CNT_W_P-1:0]           run_len
);

    logic [CNT_W_P-1:0] thr_q [NUM_EN_P];
    logic [CNT_W_P-1:0] thr_d [NUM_EN_P];
    logic [CNT_W_P-1:0] run_len_q, run_len_d;
    logic               cfg_err_q, cfg_err_d;
    logic               addr_ok;

    always_comb begin
        thr_d     = thr_q;
        run_len_d = run_len_q;
        cfg_err_d = 1'b0;
        addr_ok   = (cfg_addr <= ADDR_W_P'(NUM_EN_P));
        if (cfg_we) begin
            if (idle && addr_ok) begin
                if (cfg_addr == ADDR_W_P'(NUM_EN_P)) begin
                    run_len_d = cfg_wdata;
                end
                for (int i = 0; i < NUM_EN_P; i++) begin
                    if (cfg_addr == ADDR_W_P'(i)) begin
                        thr_d[i] = cfg_wdata;
                    end
                end
            end else begin
                cfg_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge asyn_reset) begin
        if (asyn_reset) begin
            for (int i = 0; i < NUM_EN_P; i++) begin
                thr_q[i] <= CNT_W_P'(default_thr(i));
            end
            run_len_q <= CNT_W_P'(DEFAULT_RUN_LEN);
            cfg_err_q <= 1'b0;
        end else begin
            thr_q     <= thr_d;
            run_len_q <= run_len_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    always_comb begin
        thr_flat = '0;
        for (int i = 0; i < NUM_EN_P; i++) begin
            thr_flat[i*CNT_W_P +: CNT_W_P] = thr_q[i];
        end
    end

    assign run_len = run_len_q;
    assign cfg_err = cfg_err_q;

endmodule

// File: rtl/newton_enable_scheduler.sv
// rtl/newton_enable_scheduler.sv - run counter and threshold compare driving Newton datapath enables; NEWTON_SCHED_STALL_EN adds a stall input
module newton_enable_scheduler
    import newton_sched_pkg::*;
#(
    parameter int NUM_EN_P = NUM_EN,
    parameter int CNT_W_P  = CNT_W,
    parameter int ADDR_W_P = ADDR_W
) (
    input  logic                 clk,
    input  logic                 asyn_reset,
    input  logic                 start,
    input  logic                 abort,
`ifdef NEWTON_SCHED_STALL_EN
    input  logic                 stall,
`endif
    input  logic                 cfg_we,
    input  logic [ADDR_W_P-1:0]  cfg_addr,
    input  logic [CNT_W_P-1:0]   cfg_wdata,
    output logic                 cfg_err,
    output logic [NUM_EN_P-1:0]  en,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_W_P-1:0]   cnt
);

    logic [1:0]                  state_q, state_d;
    logic [CNT_W_P-1:0]          cnt_q, cnt_d;
    logic [NUM_EN_P-1:0]         en_q, en_d;
    logic                        done_q, done_d;
    logic [NUM_EN_P*CNT_W_P-1:0] thr_flat;
    logic [CNT_W_P-1:0]          run_len;
    logic                        stall_act;

`ifdef NEWTON_SCHED_STALL_EN
    assign stall_act = stall;
`else
    assign stall_act = 1'b0;
`endif

    newton_sched_cfg_regs #(
        .NUM_EN_P (NUM_EN_P),
        .CNT_W_P  (CNT_W_P),
        .ADDR_W_P (ADDR_W_P)
    ) u_cfg_regs (
        .clk        (clk),
        .asyn_reset (asyn_reset),
        .idle       (state_q == ST_IDLE),
        .cfg_we     (cfg_we),
        .cfg_addr   (cfg_addr),
        .cfg_wdata  (cfg_wdata),
        .cfg_err    (cfg_err),
        .thr_flat   (thr_flat),
        .run_len    (run_len)
    );

    // Abort outranks stall and end-of-run; the compare uses the pre-increment count.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        en_d    = en_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                en_d = '0;
                if (start) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_d = ST_IDLE;
                    en_d    = '0;
                end else if (stall_act) begin
                    en_d = '0;
                end else if (cnt_q == run_len) begin
                    state_d = ST_DONE;
                    en_d    = '0;
                    done_d  = 1'b1;
                end else begin
                    if (cnt_q != {CNT_W_P{1'b1}}) begin
                        cnt_d = cnt_q + CNT_W_P'(1);
                    end
                    for (int i = 0; i < NUM_EN_P; i++) begin
                        en_d[i] = (cnt_q > thr_flat[i*CNT_W_P +: CNT_W_P]);
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                en_d    = '0;
            end
            default: begin
                state_d = ST_IDLE;
                en_d    = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge asyn_reset) begin
        if (asyn_reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            en_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            en_q    <= en_d;
            done_q  <= done_d;
        end
    end

    assign en   = en_q;
    assign busy = (state_q != ST_IDLE);
    assign done = done_q;
    assign cnt  = cnt_q;

endmodule
